framebuf_src: RTL and testbench

Parametrised frame-buffer pixel source: streams a down-scaled image from block RAM to the display pipeline in step with the video timing generator's `i_newframe`/`i_newline`/`i_enable` strobes. It also accepts a pixel-load stream (e.g. from the UART loader) that fills the buffer at run time. Read data is latency-aligned with a `o_valid` flag. Each channel is expanded to 8 bits by bit replication. Sits between the timing generator and the TMDS/VGA encoder.

---
 rtl/fb_pkg.sv | 32 +++
 rtl/framebuf_src_if.sv | 30 +++
 rtl/bram.sv | 30 +++
 rtl/framebuf_src.sv | 134 +++++++++++++
 tb/tb_framebuf_src.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and elaboration-time helpers for the frame-buffer pixel source.
package fb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int fb_dim(input int active, input int scale_log2);
    return active >> scale_log2;
  endfunction

  function automatic int fb_depth(input int h_active, input int v_active, input int scale_log2);
    return (h_active >> scale_log2) * (v_active >> scale_log2);
  endfunction

  function automatic int fb_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Replicates the low bpc bits MSB-first until 8 bits are filled.
  function automatic logic [7:0] expand_channel(input logic [7:0] bits, input int bpc);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[3'(7 - i)] = bits[3'(bpc - 1 - (i % bpc))];
    end
    return res;
  endfunction

endpackage

// File: rtl/framebuf_src_if.sv
// Bundle of timing strobes, pixel-load stream and pixel output for framebuf_src.
interface framebuf_src_if #(
  parameter int BPC = 3
);
  localparam int BPP = 3 * BPC;

  // Load stream: a beat transfers on every cycle where wr_valid && wr_ready;
  // wr_data is only meaningful with wr_valid and the source may not retract it.
  logic             i_newframe;
  logic             i_newline;
  logic             i_enable;
  logic             wr_restart;
  logic             wr_valid;
  logic [BPP-1:0]   wr_data;
  logic             wr_ready;
  logic             wr_done;
  logic             o_valid;
  logic [23:0]      pixel;

  modport master (
    output i_newframe, i_newline, i_enable, wr_restart, wr_valid, wr_data,
    input  wr_ready, wr_done, o_valid, pixel
  );

  modport slave (
    input  i_newframe, i_newline, i_enable, wr_restart, wr_valid, wr_data,
    output wr_ready, wr_done, o_valid, pixel
  );

endinterface

// File: rtl/bram.sv
// Simple dual-port block RAM, read-first, with a configurable read pipeline.
module bram #(
  parameter int WIDTH   = 9,
  parameter int DEPTH   = 17,
  parameter int SIZE    = 76800,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rd_q  [LATENCY];

  // Non-blocking write and read of the same word return the old contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_q[0] <= mem_q[raddr_i];
    for (int i = 1; i < LATENCY; i++) begin
      rd_q[i] <= rd_q[i-1];
    end
  end

  assign rdata_o = rd_q[LATENCY-1];

endmodule

// File: rtl/framebuf_src.sv
// Streams a down-scaled frame buffer to the video pipeline in step with the
// timing strobes, while a load stream refills the buffer concurrently.
module framebuf_src
  import fb_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_LOG2 = 1,
  parameter int BPC        = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  framebuf_src_if.slave bus
);

  localparam int BPP   = 3 * BPC;
  localparam int FB_W  = fb_dim(H_ACTIVE, SCALE_LOG2);
  localparam int DEPTH = fb_depth(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
  localparam int AW    = fb_aw(DEPTH);
  localparam int XW    = fb_aw(H_ACTIVE);
  localparam int YW    = fb_aw(V_ACTIVE);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MASK = YW'((1 << SCALE_LOG2) - 1);
  localparam logic [AW-1:0] W_LAST = AW'(DEPTH - 1);

  logic [XW-1:0]         x_q, x_d, x_cur;
  logic [YW-1:0]         y_q, y_d;
  logic [AW-1:0]         row_base_q, row_base_d, rd_addr;
  logic                  rd_req;
  logic [RD_LATENCY-1:0] vld_q;
  logic                  o_valid_q;
  rgb888_t               pixel_q, pixel_d;
  logic [BPP-1:0]        rd_data;

  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic                  wr_done_q, wr_done_d;
  logic                  wr_ready, wr_fire, wr_last;

  // Read side: row_base tracks (y >> SCALE_LOG2) * FB_W incrementally.
  always_comb begin
    rd_req     = bus.i_enable && !bus.i_newframe;
    x_cur      = bus.i_newline ? '0 : x_q;
    rd_addr    = row_base_q + AW'(x_cur >> SCALE_LOG2);
    x_d        = x_cur;
    y_d        = y_q;
    row_base_d = row_base_q;
    if (bus.i_newframe) begin
      x_d        = '0;
      y_d        = '0;
      row_base_d = '0;
    end else if (bus.i_enable) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d        = '0;
          row_base_d = '0;
        end else begin
          y_d = y_q + YW'(1);
          if ((y_q & Y_MASK) == Y_MASK) row_base_d = row_base_q + AW'(FB_W);
        end
      end else begin
        x_d = x_cur + XW'(1);
      end
    end
  end

  always_comb begin
    pixel_d = '0;
    if (vld_q[RD_LATENCY-1]) begin
      pixel_d.r = expand_channel(8'(rd_data[3*BPC-1 -: BPC]), BPC);
      pixel_d.g = expand_channel(8'(rd_data[2*BPC-1 -: BPC]), BPC);
      pixel_d.b = expand_channel(8'(rd_data[BPC-1 -: BPC]), BPC);
    end
  end

  // Write side: no backpressure outside reset.
  always_comb begin
    wr_ready  = !rst;
    wr_fire   = bus.wr_valid && wr_ready;
    wr_last   = (wr_addr_q == W_LAST);
    wr_done_d = wr_fire && wr_last;
    wr_addr_d = wr_addr_q;
    if (bus.wr_restart)  wr_addr_d = '0;
    else if (wr_fire)    wr_addr_d = wr_last ? '0 : wr_addr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      vld_q      <= '0;
      o_valid_q  <= 1'b0;
      pixel_q    <= '0;
      wr_addr_q  <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      vld_q[0]   <= rd_req;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      o_valid_q  <= vld_q[RD_LATENCY-1];
      pixel_q    <= pixel_d;
      wr_addr_q  <= wr_addr_d;
      wr_done_q  <= wr_done_d;
    end
  end

  bram #(
    .WIDTH   (BPP),
    .DEPTH   (AW),
    .SIZE    (DEPTH),
    .LATENCY (RD_LATENCY)
  ) u_bram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_addr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign bus.wr_ready = wr_ready;
  assign bus.wr_done  = wr_done_q;
  assign bus.o_valid  = o_valid_q;
  assign bus.pixel    = pixel_q;

endmodule

// File: tb/tb_framebuf_src.sv
// Randomised scoreboard bench for framebuf_src on a reduced 16x8 raster
// (2x scale, 3 bits per channel, 2-cycle BRAM latency).
module tb_framebuf_src;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int S     = 1;
  localparam int BPC   = 3;
  localparam int RDL   = 2;
  localparam int FB_W  = H >> S;
  localparam int DEPTH = (H >> S) * (V >> S);
  localparam int BPP   = 3 * BPC;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  framebuf_src_if #(.BPC(BPC)) bus ();

  framebuf_src #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .SCALE_LOG2 (S),
    .BPC        (BPC),
    .RD_LATENCY (RDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  logic [BPP-1:0] mem_m [DEPTH];
  int m_x = 0, m_y = 0, m_wa = 0;

  // scoreboard
  logic [23:0] exp_q [$];
  int          cyc_q [$];
  int          done_q[$];
  int          n_tests = 0, n_fail = 0;
  bit          mon_on  = 1'b0;

  function automatic logic [23:0] exp_pix(input logic [BPP-1:0] w);
    logic [23:0] p;
    logic [2:0]  c;
    p = '0;
    for (int k = 0; k < 3; k++) begin
      c = w[3*(2-k) +: 3];
      p[8*(2-k) +: 8] = {c, c, c[2:1]};
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // driver: one cycle of stimulus, with the model updated from the same inputs
  task automatic step(input bit en, input bit nl, input bit nf, input bit wv,
                      input logic [BPP-1:0] wd, input bit wrs);
    int a;
    bus.i_enable   = en;
    bus.i_newline  = nl;
    bus.i_newframe = nf;
    bus.wr_valid   = wv;
    bus.wr_data    = wd;
    bus.wr_restart = wrs;
    if (en && !nf) begin
      a = (m_y >> S) * FB_W + ((nl ? 0 : m_x) >> S);
      exp_q.push_back(exp_pix(mem_m[a]));
      cyc_q.push_back(cyc + RDL + 1);
    end
    if (nf) begin
      m_x = 0;
      m_y = 0;
    end else begin
      if (nl) m_x = 0;
      if (en) begin
        m_x++;
        if (m_x == H) begin
          m_x = 0;
          m_y = (m_y + 1) % V;
        end
      end
    end
    if (wv) begin
      mem_m[m_wa] = wd;
      if (m_wa == DEPTH - 1) done_q.push_back(cyc + 1);
    end
    if (wrs)     m_wa = 0;
    else if (wv) m_wa = (m_wa + 1) % DEPTH;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    bus.i_enable   = 1'b0;
    bus.i_newline  = 1'b0;
    bus.i_newframe = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_restart = 1'b0;
    rst = 1'b1;
    while (cyc_q.size() > 0 && cyc_q[$] > cyc) begin
      void'(cyc_q.pop_back());
      void'(exp_q.pop_back());
    end
    while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
    m_x  = 0;
    m_y  = 0;
    m_wa = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin : monitor
    bit de;
    if (mon_on) begin
      if (bus.o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.o_valid), 32'd0);
        end else begin
          check("pixel", 32'(bus.pixel), 32'(exp_q.pop_front()));
          check("latency", cyc, cyc_q.pop_front());
        end
      end else begin
        check("blank_pixel", 32'(bus.pixel), 32'd0);
        if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
          check("missing_valid", 32'(bus.o_valid), 32'd1);
          void'(cyc_q.pop_front());
          void'(exp_q.pop_front());
        end
      end
      de = (done_q.size() > 0 && done_q[0] == cyc);
      if (bus.wr_done === 1'b1 || de) check("wr_done", 32'(bus.wr_done), 32'(de));
      if (de) void'(done_q.pop_front());
      while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
    end
  end

  initial begin : stimulus
    int w;
    bit v;
    bus.i_enable   = 1'b0;
    bus.i_newline  = 1'b0;
    bus.i_newframe = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_restart = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    @(posedge clk);
    #1;
    mon_on = 1'b1;
    check("rst_o_valid",  32'(bus.o_valid),  32'd0);
    check("rst_pixel",    32'(bus.pixel),    32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_wr_done",  32'(bus.wr_done),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("wr_ready_after_rst", 32'(bus.wr_ready), 32'd1);

    // full buffer load with random gaps
    w = 0;
    while (w < DEPTH) begin
      v = ($urandom_range(0, 3) != 0);
      step(1'b0, 1'b0, 1'b0, v, BPP'($urandom), 1'b0);
      if (v) w++;
    end
    idle(3);

    // one whole frame back-to-back, plus two lines across the frame wrap
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (H * V + 2 * H) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // newframe colliding with an enable mid-frame; the next enable reads word 0
    repeat (H * 3 + 5) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // expansion extremes at words 0 and 1
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'h124, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    // same-address read and write in one cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, BPP'($urandom), 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // random concurrent traffic with resync strobes and write restarts
    repeat (600)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 1) == 1, BPP'($urandom), $urandom_range(0, 30) == 0);

    // reset during a read stream and a load
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 1) == 1, BPP'($urandom), 1'b0);
    pulse_reset(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, BPP'($urandom), 1'b0);
    repeat (2 * H + 3) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    idle(RDL + 3);
    check("drain_pixels", exp_q.size(), 32'd0);
    check("drain_wr_done", done_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
